// File: rtl/transducer_pkg.sv
// Shared definitions for the multi-channel transducer burst block:
// host command encodings, controller states and default widths.
package transducer_pkg;

  localparam int DEF_N_CH   = 8;
  localparam int DEF_PD_W   = 16;
  localparam int DEF_CT_W   = 9;
  localparam int DEF_NP_W   = 8;
  localparam int DEF_SAFE_W = 10;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_ARM   = 2'b01,
    CMD_FIRE  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmdT;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    FIRE  = 2'b10,
    DONE  = 2'b11
  } stateT;

  // Channel-index width; a single-channel build still gets a 1-bit index.
  function automatic int chIdxW(input int nCh);
    return (nCh > 1) ? $clog2(nCh) : 1;
  endfunction

endpackage

// File: rtl/transducer_burst_array_if.sv
// Host-side bundle of the burst array: command, shadow config write port,
// burst parameters and the transmit/status outputs.
interface transducer_burst_array_if
  import transducer_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int PD_W = DEF_PD_W,
  parameter int CT_W = DEF_CT_W,
  parameter int NP_W = DEF_NP_W
) ();

  localparam int CH_W = chIdxW(N_CH);

  logic [1:0]      cmd;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [PD_W-1:0] cfg_pd;
  logic [CT_W-1:0] cfg_ct;
  logic [NP_W-1:0] burst_np;
  logic [PD_W:0]   burst_period;
  logic [N_CH-1:0] tx_out;
  logic            armed;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic [N_CH-1:0] safety_err;

  modport master (
    output cmd, cfg_we, cfg_ch, cfg_pd, cfg_ct, burst_np, burst_period,
    input  tx_out, armed, busy, done, cfg_err, safety_err
  );

  modport slave (
    input  cmd, cfg_we, cfg_ch, cfg_pd, cfg_ct, burst_np, burst_period,
    output tx_out, armed, busy, done, cfg_err, safety_err
  );

endinterface

// File: rtl/tx_channel.sv
// One transducer output: active pd/ct, firing-window compare against the shared
// phase, and a consecutive-high safety counter that mutes the pin until cleared.
module tx_channel
  import transducer_pkg::*;
#(
  parameter int PD_W   = DEF_PD_W,
  parameter int CT_W   = DEF_CT_W,
  parameter int SAFE_W = DEF_SAFE_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PD_W-1:0] ldPd,
  input  logic [CT_W-1:0] ldCt,
  input  logic            clearFlags,
  input  logic            run,
  input  logic [PD_W:0]   phase,
  output logic            txOut,
  output logic            safetyErr
);

  localparam int SUM_W = PD_W + 2;

  logic [PD_W-1:0]   pd;
  logic [CT_W-1:0]   ct;
  logic [SAFE_W-1:0] safeCnt;
  logic [SAFE_W-1:0] safeCntNext;
  logic [SUM_W-1:0]  winStart;
  logic [SUM_W-1:0]  winEnd;
  logic [SUM_W-1:0]  phaseExt;
  logic              winHit;
  logic              trip;

  // phase is the value the shared counter takes next cycle, so the registered
  // pin lines up with the phase it belongs to.
  always_comb begin
    phaseExt    = {1'b0, phase};
    winStart    = {2'b00, pd};
    winEnd      = winStart + SUM_W'(ct);
    winHit      = run && (ct != '0) && (phaseExt >= winStart) && (phaseExt < winEnd);
    safeCntNext = txOut ? safeCnt + 1'b1 : '0;
    trip        = safeCntNext[SAFE_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pd        <= '0;
      ct        <= '0;
      safeCnt   <= '0;
      txOut     <= 1'b0;
      safetyErr <= 1'b0;
    end else begin
      if (load) begin
        pd <= ldPd;
        ct <= ldCt;
      end
      if (clearFlags) begin
        safeCnt   <= '0;
        txOut     <= 1'b0;
        safetyErr <= 1'b0;
      end else begin
        safeCnt   <= safeCntNext;
        safetyErr <= safetyErr | trip;
        // a trip landing on a window start still keeps the pin low
        txOut     <= winHit && !safetyErr && !trip;
      end
    end
  end

endmodule

// File: rtl/transducer_burst_array.sv
// Multi-channel transducer burst controller: shadow config, arm validation,
// burst FSM with phase/pulse counters, and N_CH gated output channels.
module transducer_burst_array
  import transducer_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int PD_W   = DEF_PD_W,
  parameter int CT_W   = DEF_CT_W,
  parameter int NP_W   = DEF_NP_W,
  parameter int SAFE_W = DEF_SAFE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  transducer_burst_array_if.slave bus
);

  localparam int CH_W  = chIdxW(N_CH);
  localparam int SUM_W = PD_W + 2;

  cmdT             cmd;
  stateT           state;
  stateT           stateNext;
  logic [PD_W-1:0] shPd [N_CH];
  logic [CT_W-1:0] shCt [N_CH];
  logic [PD_W:0]   phase;
  logic [PD_W:0]   phaseNext;
  logic [PD_W:0]   periodLat;
  logic [NP_W-1:0] pulse;
  logic [NP_W-1:0] pulseNext;
  logic [NP_W-1:0] npLat;
  logic            armed, armedNext;
  logic            busy, busyNext;
  logic            done, doneNext;
  logic            cfgErr, cfgErrNext;
  logic            armOk;
  logic            loadActive;
  logic            runNext;
  logic            clearFlags;
  logic            lastPhase;
  logic            lastPulse;
  logic [N_CH-1:0] txBits;
  logic [N_CH-1:0] safeBits;

  assign cmd = cmdT'(bus.cmd);

  // An index beyond N_CH-1 matches no entry and the write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        shPd[i] <= '0;
        shCt[i] <= '0;
      end
    end else if (bus.cfg_we) begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.cfg_ch == CH_W'(i)) begin
          shPd[i] <= bus.cfg_pd;
          shCt[i] <= bus.cfg_ct;
        end
      end
    end
  end

  // Every enabled channel must close its window inside one period; sum is
  // widened so a large pd+ct cannot wrap past the check.
  always_comb begin
    armOk = (bus.burst_np != '0) && (bus.burst_period != '0);
    for (int i = 0; i < N_CH; i++) begin
      if ((shCt[i] != '0) &&
          (({2'b00, shPd[i]} + SUM_W'(shCt[i])) > SUM_W'(bus.burst_period)))
        armOk = 1'b0;
    end
  end

  assign lastPhase = (phase == periodLat - 1'b1);
  assign lastPulse = (pulse == npLat - 1'b1);

  always_comb begin
    stateNext  = state;
    phaseNext  = phase;
    pulseNext  = pulse;
    armedNext  = armed;
    busyNext   = 1'b0;
    doneNext   = 1'b0;
    cfgErrNext = cfgErr;
    loadActive = 1'b0;
    runNext    = 1'b0;
    clearFlags = 1'b0;

    case (state)
      IDLE: begin
        if (cmd == CMD_ARM) begin
          if (armOk) begin
            loadActive = 1'b1;
            armedNext  = 1'b1;
            stateNext  = ARMED;
          end else begin
            cfgErrNext = 1'b1;
          end
        end
      end

      ARMED, DONE: begin
        if (cmd == CMD_ARM) begin
          if (armOk) begin
            loadActive = 1'b1;
            stateNext  = ARMED;
          end else begin
            cfgErrNext = 1'b1;
          end
        end else if (cmd == CMD_FIRE) begin
          stateNext = FIRE;
          phaseNext = '0;
          pulseNext = '0;
          busyNext  = 1'b1;
          runNext   = 1'b1;
        end
      end

      FIRE: begin
        if ((cmd == CMD_FIRE) || (cmd == CMD_ARM)) begin
          if (cmd == CMD_ARM)
            cfgErrNext = 1'b1;
          busyNext = 1'b1;
          runNext  = 1'b1;
          if (!lastPhase) begin
            phaseNext = phase + 1'b1;
          end else begin
            phaseNext = '0;
            if (lastPulse) begin
              stateNext = DONE;
              busyNext  = 1'b0;
              runNext   = 1'b0;
              doneNext  = 1'b1;
            end else begin
              pulseNext = pulse + 1'b1;
            end
          end
        end else begin
          // dropping fire releases the pins next cycle without a done pulse
          stateNext = ARMED;
        end
      end

      default: stateNext = IDLE;
    endcase

    if (cmd == CMD_CLEAR) begin
      stateNext  = IDLE;
      armedNext  = 1'b0;
      busyNext   = 1'b0;
      doneNext   = 1'b0;
      cfgErrNext = 1'b0;
      runNext    = 1'b0;
      loadActive = 1'b0;
      clearFlags = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      pulse     <= '0;
      npLat     <= '0;
      periodLat <= '0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfgErr    <= 1'b0;
    end else begin
      state  <= stateNext;
      phase  <= phaseNext;
      pulse  <= pulseNext;
      armed  <= armedNext;
      busy   <= busyNext;
      done   <= doneNext;
      cfgErr <= cfgErrNext;
      if (loadActive) begin
        npLat     <= bus.burst_np;
        periodLat <= bus.burst_period;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : genCh
    tx_channel #(
      .PD_W  (PD_W),
      .CT_W  (CT_W),
      .SAFE_W(SAFE_W)
    ) uCh (
      .clk       (clk),
      .rst       (rst),
      .load      (loadActive),
      .ldPd      (shPd[i]),
      .ldCt      (shCt[i]),
      .clearFlags(clearFlags),
      .run       (runNext),
      .phase     (phaseNext),
      .txOut     (txBits[i]),
      .safetyErr (safeBits[i])
    );
  end

  assign bus.tx_out     = txBits;
  assign bus.safety_err = safeBits;
  assign bus.armed      = armed;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.cfg_err    = cfgErr;

endmodule

// File: tb/tb_transducer_burst_array.sv
// Directed bench for transducer_burst_array: single pulse, bursts, shadow
// isolation, abort/replay, arm validation and the per-channel safety trip.
module tb_transducer_burst_array;
  import transducer_pkg::*;

  localparam int N_CH   = 8;
  localparam int PD_W   = 16;
  localparam int CT_W   = 9;
  localparam int NP_W   = 8;
  localparam int SAFE_W = 10;
  localparam int TRIP   = 512;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nErrors = 0;

  // bench-side shadow and active configuration
  int sPd [N_CH];
  int sCt [N_CH];
  int mPd [N_CH];
  int mCt [N_CH];
  int mNp;
  int mPer;
  int run [N_CH];
  logic [N_CH-1:0] muted;
  int doneK;
  int riseK;

  transducer_burst_array_if #(.N_CH(N_CH), .PD_W(PD_W), .CT_W(CT_W), .NP_W(NP_W)) bus ();

  transducer_burst_array #(
    .N_CH(N_CH), .PD_W(PD_W), .CT_W(CT_W), .NP_W(NP_W), .SAFE_W(SAFE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input int ch, input int pd, input int ct);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 3'(ch);
    bus.cfg_pd = 16'(pd);
    bus.cfg_ct = 9'(ct);
    tick();
    bus.cfg_we = 1'b0;
    sPd[ch] = pd;
    sCt[ch] = ct;
  endtask

  task automatic arm(input string tag, input int np, input int per, input bit ok,
                     input bit expArmed, input bit expErr);
    bus.burst_np     = 8'(np);
    bus.burst_period = 17'(per);
    bus.cmd          = CMD_ARM;
    tick();
    bus.cmd = CMD_IDLE;
    @(negedge clk);
    check({tag, " armed"}, 32'(bus.armed), 32'(expArmed));
    check({tag, " cfg_err"}, 32'(bus.cfg_err), 32'(expErr));
    if (ok) begin
      mPd  = sPd;
      mCt  = sCt;
      mNp  = np;
      mPer = per;
    end
    tick();
  endtask

  task automatic clearAll(input string tag);
    bus.cmd = CMD_CLEAR;
    tick();
    bus.cmd = CMD_IDLE;
    @(negedge clk);
    check({tag, " armed"}, 32'(bus.armed), 32'h0);
    check({tag, " cfg_err"}, 32'(bus.cfg_err), 32'h0);
    check({tag, " safety_err"}, 32'(bus.safety_err), 32'h0);
    check({tag, " tx_out"}, 32'(bus.tx_out), 32'h0);
    muted = '0;
    tick();
  endtask

  // Fires the active set; cycle k counts from the cycle after fire is first seen.
  task automatic fire(input string tag, input int abortAt, input int wrAt, input int wPd,
                      input int wCt, input int probe, output int doneAt, output int riseAt);
    int total;
    int lastK;
    int ph;
    bit inBurst;
    logic [N_CH-1:0] expTx;
    total  = mNp * mPer;
    doneAt = 0;
    riseAt = 0;
    lastK  = (abortAt > 0) ? abortAt + 1 : total + 2;
    for (int i = 0; i < N_CH; i++) run[i] = 0;
    bus.cmd = CMD_FIRE;
    for (int k = 1; k <= lastK; k++) begin
      tick();
      bus.cfg_we = (k == wrAt);
      if (k == wrAt) begin
        bus.cfg_ch = '0;
        bus.cfg_pd = 16'(wPd);
        bus.cfg_ct = 9'(wCt);
        sPd[0] = wPd;
        sCt[0] = wCt;
      end
      if ((k == total + 1) || (k == abortAt)) bus.cmd = CMD_IDLE;
      @(negedge clk);
      inBurst = ((k - 1) < total) && !((abortAt > 0) && (k > abortAt));
      ph      = (k - 1) % mPer;
      expTx   = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (inBurst && (mCt[i] != 0) && (ph >= mPd[i]) && (ph < mPd[i] + mCt[i])) begin
          if (run[i] == TRIP) muted[i] = 1'b1;
          if (!muted[i]) expTx[i] = 1'b1;
        end
        run[i] = expTx[i] ? run[i] + 1 : 0;
      end
      check({tag, " tx_out"}, 32'(bus.tx_out), 32'(expTx));
      check({tag, " busy"}, 32'(bus.busy), 32'(inBurst));
      check({tag, " done"}, 32'(bus.done), 32'(k == total + 1));
      check({tag, " safety_err"}, 32'(bus.safety_err), 32'(muted));
      check({tag, " armed"}, 32'(bus.armed), 32'h1);
      if (bus.done && (doneAt == 0)) doneAt = k;
      if (bus.tx_out[probe] && (riseAt == 0)) riseAt = k;
    end
    bus.cfg_we = 1'b0;
    bus.cmd    = CMD_IDLE;
  endtask

  initial begin
    rst              = 1'b1;
    bus.cmd          = CMD_IDLE;
    bus.cfg_we       = 1'b0;
    bus.cfg_ch       = '0;
    bus.cfg_pd       = '0;
    bus.cfg_ct       = '0;
    bus.burst_np     = '0;
    bus.burst_period = '0;
    muted            = '0;
    mNp              = 0;
    mPer             = 1;
    for (int i = 0; i < N_CH; i++) begin
      sPd[i] = 0; sCt[i] = 0; mPd[i] = 0; mCt[i] = 0; run[i] = 0;
    end

    repeat (3) tick();
    @(negedge clk);
    check("reset tx_out", 32'(bus.tx_out), 32'h0);
    check("reset armed", 32'(bus.armed), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset done", 32'(bus.done), 32'h0);
    check("reset cfg_err", 32'(bus.cfg_err), 32'h0);
    check("reset safety_err", 32'(bus.safety_err), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // single pulse: ch0 high k=4..8, ch1 k=1..2, done k=11
    cfgWrite(0, 3, 5);
    cfgWrite(1, 0, 2);
    arm("t1 arm", 1, 10, 1'b1, 1'b1, 1'b0);
    fire("t1", 0, 0, 0, 0, 0, doneK, riseK);
    check("t1 done cycle", 32'(doneK), 32'd11);
    check("t1 ch0 rise", 32'(riseK), 32'd4);

    // burst of 3, ch0 shadow rewritten mid-burst must not leak in
    cfgWrite(0, 0, 0);
    cfgWrite(1, 0, 0);
    cfgWrite(2, 5, 4);
    arm("t2 arm", 3, 20, 1'b1, 1'b1, 1'b0);
    fire("t2", 0, 10, 1, 2, 2, doneK, riseK);
    check("t2 done cycle", 32'(doneK), 32'd61);
    check("t2 ch2 rise", 32'(riseK), 32'd6);
    fire("t2 refire", 0, 0, 0, 0, 0, doneK, riseK);
    check("t2 refire done", 32'(doneK), 32'd61);
    check("t2 refire ch0 idle", 32'(riseK), 32'd0);
    arm("t2 rearm", 3, 20, 1'b1, 1'b1, 1'b0);
    fire("t2 new", 0, 0, 0, 0, 0, doneK, riseK);
    check("t2 new ch0 rise", 32'(riseK), 32'd2);

    // abort mid-pulse, then a full replay
    fire("t3 abort", 7, 0, 0, 0, 2, doneK, riseK);
    check("t3 abort no done", 32'(doneK), 32'd0);
    check("t3 abort ch2 rise", 32'(riseK), 32'd6);
    fire("t3 replay", 0, 0, 0, 0, 2, doneK, riseK);
    check("t3 replay done", 32'(doneK), 32'd61);

    // arm validation
    clearAll("t4 clr");
    cfgWrite(3, 18, 4);
    arm("t4 bad", 1, 20, 1'b0, 1'b0, 1'b1);
    clearAll("t4 clr2");
    cfgWrite(3, 16, 4);
    arm("t4 edge", 1, 20, 1'b1, 1'b1, 1'b0);
    arm("t4 np0", 0, 20, 1'b0, 1'b1, 1'b1);
    arm("t4 per0", 1, 0, 1'b0, 1'b1, 1'b1);
    fire("t4 fire", 0, 0, 0, 0, 3, doneK, riseK);
    check("t4 done cycle", 32'(doneK), 32'd21);
    check("t4 ch3 rise", 32'(riseK), 32'd17);

    // safety: ch4 fills whole periods so it stays high across pulses
    clearAll("t5 clr");
    cfgWrite(0, 0, 0);
    cfgWrite(2, 0, 0);
    cfgWrite(3, 0, 0);
    cfgWrite(4, 0, 300);
    cfgWrite(5, 10, 5);
    arm("t5 arm", 3, 300, 1'b1, 1'b1, 1'b0);
    fire("t5", 0, 0, 0, 0, 4, doneK, riseK);
    check("t5 done cycle", 32'(doneK), 32'd901);
    check("t5 safety_err", 32'(bus.safety_err), 32'h10);
    clearAll("t5 clr2");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/transducer_burst_array.md
Name: transducer_burst_array

Overview:
- Multi-channel successor to the single-channel transducer pulse output block.
- Drives N_CH transducer outputs, each with its own phase delay (pd) and charge time (ct), from an internal phase counter.
- Supports multi-pulse bursts at a programmable period, double-buffered per-channel configuration, per-channel safety valves and config-error checking.
- Sits between the host register file (shadow writes, 2-bit cmd) and the transmit pins.

Parameters:
- N_CH, 8, number of transducer channels.
- PD_W, 16, phase-delay width.
- CT_W, 9, charge-time width.
- NP_W, 8, burst pulse-count width.
- SAFE_W, 10, safety counter width. Trip threshold is 2^(SAFE_W-1) consecutive high cycles; must exceed 2^CT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd  in  2  00 idle, 01 arm, 10 fire, 11 clear.
- cfg_we  in  1  shadow write strobe.
- cfg_ch  in  clog2(N_CH)  shadow write channel index.
- cfg_pd  in  PD_W  shadow phase delay.
- cfg_ct  in  CT_W  shadow charge time; 0 = channel disabled.
- burst_np  in  NP_W  pulses per burst, sampled at arm.
- burst_period  in  PD_W+1  cycles per pulse, sampled at arm.
- tx_out  out  N_CH  registered transducer drive.
- armed  out  1  active set loaded and valid.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- cfg_err  out  1  sticky: arm rejected or arm while busy.
- safety_err  out  N_CH  sticky per-channel safety trip.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, shadow/active pd and ct 0, counters 0, FSM in IDLE.
- Shadow writes: cfg_we writes shadow[cfg_ch] in any state, effective next cycle. An out-of-range cfg_ch is ignored. Shadow writes never alter the active set.
- FSM states: IDLE, ARMED, FIRE, DONE.
- IDLE, cmd=01 (arm), validation:
  - Require burst_np != 0.
  - Require burst_period != 0.
  - For every channel with ct != 0, require pd+ct <= burst_period, computed at PD_W+2 bits with no wrap.
  - Pass: copy shadow to active, latch np/period, go to ARMED, armed=1 next cycle.
  - Fail: cfg_err=1, stay in IDLE.
- cmd=01 in ARMED: re-validates and reloads.
- cmd=01 in FIRE: sets cfg_err, burst continues unaffected.
- ARMED, cmd=10 seen at cycle t:
  - Go to FIRE; phase=0 and pulse=0 at t+1; busy=1 from t+1.
- FIRE timing:
  - phase increments every cycle and wraps to 0 at burst_period-1, incrementing pulse.
  - tx_out[i]=1 while pd_i <= phase < pd_i+ct_i, with ct_i != 0 and safety_err[i]=0.
  - Latency: rising edge at t+1+k*period+pd_i, high for exactly ct_i cycles.
  - After the last phase of pulse np-1: tx_out all 0, busy=0, done=1 for one cycle, go to DONE.
- DONE: holds armed=1. A new cmd=10 re-fires the same active set. cmd=01 re-arms.
- Abort: cmd != 10 during FIRE forces tx_out=0 next cycle, busy=0, no done pulse, state returns to ARMED. cmd=11 aborts the burst and also clears the flags (see below).
- cmd=11 (clear), from any state: tx_out=0, clear cfg_err and safety_err, armed=0, go to IDLE.
- cmd=00 (idle): tx_out forced 0. It does not disarm.
- Safety valve, per channel: counter increments while tx_out[i]=1 and clears when it is 0. When MSB is set, tx_out[i]=0 next cycle, safety_err[i]=1, and the channel stays muted until cmd=11 or rst.
- Simultaneous events:
  - rst overrides everything.
  - A safety trip in the same cycle as a window start keeps the output low.
  - cfg_we coinciding with arm: the arm copies the old shadow value.

Decomposition:
- Shared package transducer_pkg holds:
  - cmd encodings CMD_IDLE/ARM/FIRE/CLEAR;
  - FSM state typedef;
  - default widths.
- One sub-module per channel, tx_channel: holds active pd/ct, window compare, safety counter and sticky safety_err. It is instantiated N_CH times via generate.
- The top level holds the FSM, phase and pulse counters, and the arm validation.

Test Plan:
- Single pulse: ch0 pd=3 ct=5, ch1 pd=0 ct=2, np=1, period=10; arm, then fire at t -> ch0 high t+4..t+8, ch1 high t+1..t+2, done at t+11.
- Burst: np=3, period=20, ch2 pd=5 ct=4 -> three 4-cycle pulses starting t+6, t+26, t+46; single done pulse; busy low afterwards.
- Config error: ch3 pd=18 ct=4 with period=20 -> cfg_err=1, armed stays 0; cmd=11 clears cfg_err.
- Abort: cmd changes 10->00 mid-pulse -> all tx_out 0 next cycle, no done, armed=1; a re-fire replays the full burst.
- Safety: force a channel's window compare high (SAFE_W=10) -> tx_out drops after 512 high cycles, safety_err[i]=1, other channels unaffected.
- Shadow isolation: cfg_we on ch0 during FIRE -> current burst unchanged; the new values take effect only after the next arm.
